// File: rtl/int_to_int_issue_ctrl.sv
// Job-level issue controller for the int_to_int_array datapath: streams source
// vectors through a read / array-issue / write pipeline and signals completion.
module int_to_int_issue_ctrl #(
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                job_vld,
  output logic                job_rdy,
  input  logic [5:0]          job_cfg,
  input  logic [ADDR_W-1:0]   job_src_addr,
  input  logic [ADDR_W-1:0]   job_dst_addr,
  input  logic [ADDR_W:0]     job_len,
  output logic                src_rd_en,
  output logic [ADDR_W-1:0]   src_rd_addr,
  input  logic [127:0]        src_rd_data,
  output logic [6:0]          cru_inttoint_out,
  output logic [127:0]        dvr_inttoint_s_out,
  input  logic [127:0]        dr_inttoint_d_in,
  output logic                dst_wr_en,
  output logic [ADDR_W-1:0]   dst_wr_addr,
  output logic [127:0]        dst_wr_data,
  output logic                job_done,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state;
  logic [5:0]          cfg_q;
  logic [ADDR_W-1:0]   dst_ptr;
  logic [ADDR_W:0]     rd_left;
  logic                res_vld;

  // res_vld marks the cycle in which the array's registered result belongs to a
  // real issue; it is cleared by reset so stale results are never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cfg_q              <= '0;
      dst_ptr            <= '0;
      rd_left            <= '0;
      res_vld            <= 1'b0;
      job_rdy            <= 1'b1;
      src_rd_en          <= 1'b0;
      src_rd_addr        <= '0;
      cru_inttoint_out   <= '0;
      dvr_inttoint_s_out <= '0;
      dst_wr_en          <= 1'b0;
      dst_wr_addr        <= '0;
      dst_wr_data        <= '0;
      job_done           <= 1'b0;
      busy               <= 1'b0;
    end else begin
      if (src_rd_en) begin
        dvr_inttoint_s_out <= src_rd_data;
        cru_inttoint_out   <= {1'b1, cfg_q};
      end else begin
        dvr_inttoint_s_out <= '0;
        cru_inttoint_out   <= '0;
      end

      res_vld <= cru_inttoint_out[6];

      if (res_vld) begin
        dst_wr_en   <= 1'b1;
        dst_wr_data <= dr_inttoint_d_in;
        dst_wr_addr <= dst_ptr;
        dst_ptr     <= dst_ptr + 1'b1;
      end else begin
        dst_wr_en <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (job_vld) begin
            cfg_q   <= job_cfg;
            dst_ptr <= job_dst_addr;
            job_rdy <= 1'b0;
            busy    <= 1'b1;
            if (job_len != '0) begin
              state       <= ISSUE;
              src_rd_en   <= 1'b1;
              src_rd_addr <= job_src_addr;
              rd_left     <= job_len - 1'b1;
            end else begin
              state    <= DONE;
              job_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (rd_left != '0) begin
            src_rd_addr <= src_rd_addr + 1'b1;
            rd_left     <= rd_left - 1'b1;
          end else begin
            src_rd_en <= 1'b0;
            state     <= DRAIN;
          end
        end
        // The pipeline carries no bubbles, so the write with nothing behind it is the last one.
        DRAIN: begin
          if (dst_wr_en && !res_vld && !cru_inttoint_out[6] && !src_rd_en) begin
            state    <= DONE;
            job_done <= 1'b1;
          end
        end
        DONE: begin
          job_done <= 1'b0;
          busy     <= 1'b0;
          job_rdy  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_int_issue_ctrl.sv
// Scoreboard bench for int_to_int_issue_ctrl: expected reads, issues, writes and
// done pulses are queued per job with their cycle and checked every cycle.
module tb_int_to_int_issue_ctrl;

  logic         clk;
  logic         rst_n;
  logic         job_vld;
  logic         job_rdy;
  logic [5:0]   job_cfg;
  logic [5:0]   job_src_addr;
  logic [5:0]   job_dst_addr;
  logic [6:0]   job_len;
  logic         src_rd_en;
  logic [5:0]   src_rd_addr;
  logic [127:0] src_rd_data;
  logic [6:0]   cru_inttoint_out;
  logic [127:0] dvr_inttoint_s_out;
  logic [127:0] dr_inttoint_d_in;
  logic         dst_wr_en;
  logic [5:0]   dst_wr_addr;
  logic [127:0] dst_wr_data;
  logic         job_done;
  logic         busy;

  typedef struct {
    logic [5:0]   addr;
    logic [6:0]   cru;
    logic [127:0] data;
    int           cyc;
  } ev_t;

  ev_t          rdQ[$];
  ev_t          issQ[$];
  ev_t          wrQ[$];
  int           doneQ[$];
  logic [127:0] srcMem [64];
  logic [127:0] arrQ;
  int           cyc;
  int           t0;
  int           tests;
  int           fails;

  int_to_int_issue_ctrl #(.ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_vld(job_vld), .job_rdy(job_rdy), .job_cfg(job_cfg),
    .job_src_addr(job_src_addr), .job_dst_addr(job_dst_addr), .job_len(job_len),
    .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .cru_inttoint_out(cru_inttoint_out), .dvr_inttoint_s_out(dvr_inttoint_s_out),
    .dr_inttoint_d_in(dr_inttoint_d_in),
    .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data),
    .job_done(job_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural conversion array: registered result of whatever is driven to it.
  function automatic logic [127:0] arrayModel(input logic [127:0] v, input logic [5:0] cfg);
    logic [127:0]       r;
    logic signed [31:0] lane;
    logic [15:0]        s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      lane = v[32*i +: 32];
      if (cfg == 6'b101101) begin
        if (lane > 32767) s = 16'h7FFF;
        else if (lane < -32768) s = 16'h8000;
        else s = lane[15:0];
        r[32*i +: 32] = {s, 16'h0000};
      end else if (cfg == 6'b010000) begin
        r[32*i +: 32] = {16'h0000, lane[15:0]};
      end else begin
        r[32*i +: 32] = lane ^ {26'h0, cfg};
      end
    end
    return r;
  endfunction

  always @(posedge clk) arrQ <= arrayModel(dvr_inttoint_s_out, cru_inttoint_out[5:0]);
  assign dr_inttoint_d_in = arrQ;
  assign src_rd_data      = src_rd_en ? srcMem[src_rd_addr] : '0;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic monitorCycle();
    logic expRd, expIss, expWr, expDone;
    ev_t  e;
    if (!rst_n) return;
    expRd = (rdQ.size() != 0) && (rdQ[0].cyc == cyc);
    checkOutput("rd_en", src_rd_en, expRd);
    if (expRd) begin
      e = rdQ.pop_front();
      checkOutput("rd_addr", src_rd_addr, e.addr);
    end
    expIss = (issQ.size() != 0) && (issQ[0].cyc == cyc);
    checkOutput("cru_vld", cru_inttoint_out[6], expIss);
    if (expIss) begin
      e = issQ.pop_front();
      checkOutput("cru", cru_inttoint_out, e.cru);
      checkOutput("dvr", dvr_inttoint_s_out, e.data);
    end else begin
      checkOutput("cru_idle", cru_inttoint_out, 0);
      checkOutput("dvr_idle", dvr_inttoint_s_out, 0);
    end
    expWr = (wrQ.size() != 0) && (wrQ[0].cyc == cyc);
    checkOutput("wr_en", dst_wr_en, expWr);
    if (expWr) begin
      e = wrQ.pop_front();
      checkOutput("wr_addr", dst_wr_addr, e.addr);
      checkOutput("wr_data", dst_wr_data, e.data);
    end
    expDone = (doneQ.size() != 0) && (doneQ[0] == cyc);
    checkOutput("job_done", job_done, expDone);
    if (expDone) void'(doneQ.pop_front());
  endtask

  task automatic stepCycle();
    @(negedge clk);
    monitorCycle();
    #1;
  endtask

  task automatic pushExpect(input logic [5:0] cfg, input logic [5:0] src, input logic [5:0] dst,
                            input logic [6:0] len, input int start);
    ev_t        e;
    logic [5:0] a;
    logic [5:0] d;
    if (len == 0) begin
      doneQ.push_back(start + 1);
    end else begin
      for (int k = 0; k < int'(len); k++) begin
        a = src + 6'(k);
        d = dst + 6'(k);
        e.addr = a;  e.cru = 7'h0;          e.data = '0;                            e.cyc = start + 1 + k;
        rdQ.push_back(e);
        e.addr = '0; e.cru = {1'b1, cfg};   e.data = srcMem[a];                     e.cyc = start + 2 + k;
        issQ.push_back(e);
        e.addr = d;  e.cru = 7'h0;          e.data = arrayModel(srcMem[a], cfg);    e.cyc = start + 4 + k;
        wrQ.push_back(e);
      end
      doneQ.push_back(start + 4 + int'(len));
    end
  endtask

  task automatic applyStimulus(input logic [5:0] cfg, input logic [5:0] src, input logic [5:0] dst,
                               input logic [6:0] len);
    int n;
    n = 0;
    while (!job_rdy && n < 300) begin
      stepCycle();
      n++;
    end
    checkOutput("job_rdy_before_accept", job_rdy, 1);
    job_vld      = 1'b1;
    job_cfg      = cfg;
    job_src_addr = src;
    job_dst_addr = dst;
    job_len      = len;
    t0 = cyc;
    pushExpect(cfg, src, dst, len, t0);
    stepCycle();
    job_vld      = 1'b0;
    job_cfg      = 6'($urandom);
    job_src_addr = 6'($urandom);
    job_dst_addr = 6'($urandom);
    job_len      = 7'($urandom);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy || !job_rdy || rdQ.size() != 0 || issQ.size() != 0 || wrQ.size() != 0 ||
            doneQ.size() != 0) && n < 400) begin
      stepCycle();
      n++;
    end
    checkOutput("idle_busy", busy, 0);
    checkOutput("queues_drained", rdQ.size() + issQ.size() + wrQ.size() + doneQ.size(), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; job_vld = 1'b0; job_cfg = '0;
    job_src_addr = '0; job_dst_addr = '0; job_len = '0;
    for (int i = 0; i < 64; i++) srcMem[i] = {$urandom, $urandom, $urandom, $urandom};
    srcMem[0] = {4{32'h00007FFF}};
    srcMem[1] = {4{32'h00008000}};
    srcMem[2] = {4{32'hFFFF8000}};
    srcMem[3] = {4{32'hFFFF7FFF}};

    repeat (3) stepCycle();
    checkOutput("rst_job_rdy", job_rdy, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rd_en", src_rd_en, 0);
    checkOutput("rst_cru", cru_inttoint_out, 0);
    checkOutput("rst_wr_en", dst_wr_en, 0);
    checkOutput("rst_wr_addr", dst_wr_addr, 0);
    checkOutput("rst_done", job_done, 0);
    rst_n = 1'b1;
    repeat (2) stepCycle();

    // Saturating s32 -> s16 job.
    applyStimulus(6'b101101, 6'h00, 6'h10, 7'd4);
    checkOutput("busy_c1", busy, 1);
    checkOutput("rdy_c1", job_rdy, 0);
    waitIdle();

    applyStimulus(6'b010000, 6'h20, 6'h30, 7'd1);
    waitIdle();

    applyStimulus(6'b110011, 6'h05, 6'h06, 7'd0);
    checkOutput("len0_busy_c1", busy, 1);
    waitIdle();

    // Address wrap-around on both ports.
    applyStimulus(6'b001010, 6'h3E, 6'h3F, 7'd3);
    waitIdle();

    // Back-to-back: second request held from cycle 1 of the first job.
    applyStimulus(6'b101101, 6'h00, 6'h20, 7'd3);
    job_vld = 1'b1; job_cfg = 6'b011100; job_src_addr = 6'h08; job_dst_addr = 6'h28; job_len = 7'd2;
    while (cyc - t0 < 3 + 5) begin
      checkOutput("b2b_rdy_low", job_rdy, 0);
      stepCycle();
    end
    checkOutput("b2b_rdy_high", job_rdy, 1);
    t0 = cyc;
    pushExpect(6'b011100, 6'h08, 6'h28, 7'd2, t0);
    stepCycle();
    job_vld = 1'b0;
    waitIdle();

    // Longest legal job wraps the whole register file.
    applyStimulus(6'b000111, 6'h05, 6'h07, 7'd127);
    waitIdle();

    // Mid-job asynchronous reset, then a fresh job.
    applyStimulus(6'b101101, 6'h10, 6'h18, 7'd8);
    while (cyc - t0 < 3) stepCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_job_rdy", job_rdy, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_rd_en", src_rd_en, 0);
    checkOutput("midrst_cru", cru_inttoint_out, 0);
    checkOutput("midrst_dvr", dvr_inttoint_s_out, 0);
    checkOutput("midrst_wr_en", dst_wr_en, 0);
    checkOutput("midrst_done", job_done, 0);
    rdQ.delete(); issQ.delete(); wrQ.delete(); doneQ.delete();
    #1;
    rst_n = 1'b1;
    repeat (10) stepCycle();
    checkOutput("postrst_rdy", job_rdy, 1);
    applyStimulus(6'b010000, 6'h30, 6'h3A, 7'd2);
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
